// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexed driver for an eight-digit, common-anode seven-segment
// display. Each digit gets a slot of REFRESH_DIV cycles. The first
// BLANK_CYCLES cycles of every slot are dark so that one digit cannot
// ghost onto the next. The display word for a slot is captured once, on the
// first edge of that slot, so changes mid-slot cannot glitch the lit digit.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   d1..d8      display words {enable, hex[3:0], dp_off}; d1 = rightmost digit
//   an          anodes, active-low; an[k] lights the digit fed by d(k+1)
//   seg         cathodes, active-low, {dp,g,f,e,d,c,b,a}
//   digit_idx   current slot index (live copy of the slot counter)
//   frame_start one-cycle registered pulse at the start of slot 0
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic [2:0] digit_idx,
  output logic       frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [5:0]       r_cur;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;
  logic             r_frame_start;

  logic [5:0]       w_d_sel;
  logic [6:0]       w_lit;

  // Segments lit for a hex value, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] lit;
    lit = 7'b0000000;
    case (v)
      4'h0: lit = 7'b0111111;
      4'h1: lit = 7'b0000110;
      4'h2: lit = 7'b1011011;
      4'h3: lit = 7'b1001111;
      4'h4: lit = 7'b1100110;
      4'h5: lit = 7'b1101101;
      4'h6: lit = 7'b1111101;
      4'h7: lit = 7'b0000111;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1101111;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b1111100;
      4'hC: lit = 7'b0111001;
      4'hD: lit = 7'b1011110;
      4'hE: lit = 7'b1111001;
      4'hF: lit = 7'b1110001;
      default: lit = 7'b0000000;
    endcase
    return lit;
  endfunction

  always_comb begin
    w_d_sel = d1;
    case (r_idx)
      3'd0: w_d_sel = d1;
      3'd1: w_d_sel = d2;
      3'd2: w_d_sel = d3;
      3'd3: w_d_sel = d4;
      3'd4: w_d_sel = d5;
      3'd5: w_d_sel = d6;
      3'd6: w_d_sel = d7;
      3'd7: w_d_sel = d8;
      default: w_d_sel = d1;
    endcase
  end

  assign w_lit = seg_decode(r_cur[4:1]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_cur         <= 6'h00;
      r_an          <= 8'hFF;
      r_seg         <= 8'hFF;
      r_frame_start <= 1'b0;
    end else begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Capture on the first edge of the slot; the blank window guarantees
      // r_cur is settled before it reaches the pins.
      if (r_cnt == '0) begin
        r_cur <= w_d_sel;
      end

      if (r_cnt < CNT_BLANK) begin
        r_an  <= 8'hFF;
        r_seg <= 8'hFF;
      end else begin
        // A disabled digit keeps its cathodes driven but its anode off.
        r_seg <= {r_cur[0], ~w_lit};
        r_an  <= r_cur[5] ? ~(8'd1 << r_idx) : 8'hFF;
      end

      r_frame_start <= (r_idx == 3'd0) && (r_cnt == '0);
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign digit_idx   = r_idx;
  assign frame_start = r_frame_start;

endmodule
